float_divider: RTL and testbench

- IEEE-754 single-precision divider computing result = a / b, with error, overflow and underflow status flags.
- Single clock domain; operands are sampled on an in_valid cycle and the registered result appears one cycle later.
- Used as an arithmetic leaf block by FP datapaths that need full special-value and subnormal handling.

---
 rtl/fp32_pkg.sv | 53 +++++
 rtl/fdiv_mant_div.sv | 31 +++
 rtl/float_divider.sv | 148 ++++++++++++++
 tb/tb_float_divider.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision definitions.
// Field widths, constants and operand classification.
package fp32_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = 24;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] MIN_SUB = 32'h0000_0001;

  typedef enum logic [2:0] {
    ZERO,
    SUBNORMAL,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

  function automatic fp_class_t classify(
    input logic [EXP_W-1:0]  e,
    input logic [FRAC_W-1:0] f
  );
    fp_class_t c;
    if (e == '0)
      c = (f == '0) ? ZERO : SUBNORMAL;
    else if (e == '1)
      c = (f == '0) ? INF : NAN;
    else
      c = NORMAL;
    return c;
  endfunction

  function automatic logic [4:0] lzc24(
    input logic [MANT_W-1:0] m
  );
    logic [4:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!hit) begin
        if (m[i]) hit = 1'b1;
        else      n   = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fdiv_mant_div.sv
// Combinational restoring divider for normalised 24-bit mantissas.
// Produces 25 quotient bits plus guard, round and sticky.
module fdiv_mant_div (
  input  logic [23:0] num,
  input  logic [23:0] den,
  output logic [24:0] quot,
  output logic        guard,
  output logic        round,
  output logic        sticky
);

  logic [26:0] q;
  logic [24:0] rem;

  always_comb begin
    q   = '0;
    rem = {1'b0, num};
    for (int i = 26; i >= 0; i--) begin
      if (rem >= {1'b0, den}) begin
        q[i] = 1'b1;
        rem  = rem - {1'b0, den};
      end
      rem = rem << 1;
    end
    quot   = q[26:2];
    guard  = q[1];
    round  = q[0];
    sticky = |rem;
  end

endmodule

// File: rtl/float_divider.sv
// IEEE-754 single-precision divider, one-cycle registered result.
// Handles specials, subnormals, RNE rounding and status flags.
module float_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        error,
  output logic        overflow,
  output logic        underflow
);

  fp_class_t ca, cb;
  logic        sign;
  logic [7:0]  ea_raw, eb_raw;
  logic [4:0]  lza, lzb;
  logic [23:0] ma, mb, ma_n, mb_n;
  logic signed [11:0] ea, eb;

  always_comb begin
    ca     = classify(a[30:23], a[22:0]);
    cb     = classify(b[30:23], b[22:0]);
    sign   = a[31] ^ b[31];
    ma     = {|a[30:23], a[22:0]};
    mb     = {|b[30:23], b[22:0]};
    lza    = lzc24(ma);
    lzb    = lzc24(mb);
    ma_n   = ma << lza;
    mb_n   = mb << lzb;
    ea_raw = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb_raw = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ea = $signed({4'b0, ea_raw}) - $signed({7'b0, lza});
    eb = $signed({4'b0, eb_raw}) - $signed({7'b0, lzb});
  end

  logic [24:0] quot;
  logic        q_g, q_r, q_s;

  fdiv_mant_div u_mant_div (
    .num    (ma_n),
    .den    (mb_n),
    .quot   (quot),
    .guard  (q_g),
    .round  (q_r),
    .sticky (q_s)
  );

  logic signed [11:0] qexp;
  logic [23:0] mant;
  logic        g, r, s;
  logic        inc;
  logic [30:0] packed_v;
  logic [11:0] sh;
  logic [4:0]  shc;
  logic [25:0] ext, shr, mask;
  logic        st;
  logic [31:0] res_n;
  logic        err_n, ovf_n, unf_n;

  always_comb begin
    mant     = quot[24] ? quot[24:1] : quot[23:0];
    g        = quot[24] ? quot[0]    : q_g;
    r        = quot[24] ? q_g        : q_r;
    s        = quot[24] ? (q_r | q_s) : q_s;
    qexp     = ea - eb
             + (quot[24] ? 12'sd127 : 12'sd126);
    inc      = 1'b0;
    packed_v = '0;
    sh       = '0;
    shc      = '0;
    ext      = {mant, g, r};
    shr      = '0;
    mask     = '0;
    st       = 1'b0;
    res_n    = '0;
    err_n    = 1'b0;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;

    if (ca == NAN || cb == NAN
        || (ca == ZERO && cb == ZERO)
        || (ca == INF && cb == INF)) begin
      res_n = QNAN;
      err_n = 1'b1;
    end else if (cb == ZERO && ca != INF) begin
      res_n = POS_INF | {sign, 31'd0};
      ovf_n = 1'b1;
    end else if (ca == INF) begin
      res_n = POS_INF | {sign, 31'd0};
    end else if (ca == ZERO || cb == INF) begin
      res_n = {sign, 31'd0};
    end else if (qexp >= 12'sd255) begin
      res_n = POS_INF | {sign, 31'd0};
      ovf_n = 1'b1;
    end else if (qexp >= 12'sd1) begin
      inc      = g & (r | s | mant[0]);
      packed_v = {qexp[7:0], mant[22:0]}
               + {30'd0, inc};
      if (packed_v[30:23] == 8'hFF) begin
        res_n = POS_INF | {sign, 31'd0};
        ovf_n = 1'b1;
      end else begin
        res_n = {sign, packed_v};
      end
    end else begin
      // Denormalise: shift right with sticky, then round
      sh   = 12'sd1 - qexp;
      shc  = (sh > 12'd26) ? 5'd26 : sh[4:0];
      shr  = ext >> shc;
      mask = (26'd1 << shc) - 26'd1;
      st   = s | (|(ext & mask));
      inc  = shr[1] & (shr[0] | st | shr[2]);
      packed_v = {7'd0, shr[25:2]}
               + {30'd0, inc};
      if (packed_v == '0) begin
        res_n = MIN_SUB | {sign, 31'd0};
        unf_n = 1'b1;
      end else begin
        res_n = {sign, packed_v};
        unf_n = ~packed_v[23];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      error     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result    <= res_n;
        error     <= err_n;
        overflow  <= ovf_n;
        underflow <= unf_n;
      end
    end
  end

endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider against a real-arithmetic
// reference with explicit round-to-nearest-even conversion.
module tb_float_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] result;
  logic        error, overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res;
  logic [2:0]  exp_flg;

  float_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .error     (error),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h",
             tag, obs, expv);
    end
  endtask

  function automatic real mag(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) begin
      m = real'(x[22:0]);
      e = -149;
    end else begin
      m = real'({1'b1, x[22:0]});
      e = int'(x[30:23]) - 150;
    end
    return m * (2.0 ** e);
  endfunction

  task automatic ref_div(input  logic [31:0] x,
                         input  logic [31:0] y,
                         output logic [31:0] r,
                         output logic [2:0]  f);
    logic xn, yn, xi, yi, xz, yz, sg;
    real  q;
    logic [63:0] d, dm, kept, remv, mask, half;
    int   E, sh;
    longint p;
    xn = (&x[30:23]) && (|x[22:0]);
    yn = (&y[30:23]) && (|y[22:0]);
    xi = (&x[30:23]) && !(|x[22:0]);
    yi = (&y[30:23]) && !(|y[22:0]);
    xz = (x[30:0] == 31'd0);
    yz = (y[30:0] == 31'd0);
    sg = x[31] ^ y[31];
    r  = '0;
    f  = 3'b000;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      r = 32'h7FC00000; f = 3'b100;
    end else if (yz && !xi) begin
      r = {sg, 31'h7F800000}; f = 3'b010;
    end else if (xi) begin
      r = {sg, 31'h7F800000};
    end else if (xz || yi) begin
      r = {sg, 31'd0};
    end else begin
      q  = mag(x) / mag(y);
      d  = $realtobits(q);
      E  = int'(d[62:52]) - 1023 + 127;
      dm = {11'd0, 1'b1, d[51:0]};
      sh = 29;
      if (E < 1) sh = 29 + 1 - E;
      if (sh > 60) sh = 60;
      kept = dm >> sh;
      mask = (64'd1 << sh) - 64'd1;
      remv = dm & mask;
      half = 64'd1 << (sh - 1);
      if (remv > half || (remv == half && kept[0]))
        kept = kept + 64'd1;
      if (E >= 1)
        p = longint'(E) * 64'sd8388608
          + longint'(kept) - 64'sd8388608;
      else
        p = longint'(kept);
      if (p >= 64'sh7F800000) begin
        r = {sg, 31'h7F800000}; f = 3'b010;
      end else if (p == 0) begin
        r = {sg, 31'd1}; f = 3'b001;
      end else begin
        r = {sg, p[30:0]};
        f = (p < 64'sd8388608) ? 3'b001 : 3'b000;
      end
    end
  endtask

  task automatic send(input string tag,
                      input logic [31:0] x,
                      input logic [31:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    ref_div(x, y, exp_res, exp_flg);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".res"}, result, exp_res);
    chk({tag, ".flags"},
        {29'd0, error, overflow, underflow},
        {29'd0, exp_flg});
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".hold"}, result, exp_res);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: v[30:0] = 31'd0;
      1: v[30:0] = 31'h7F800000;
      2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3, 4: begin v[30:23] = 8'd0; v[5] = 1'b1; end
      5: v[30:23] = 8'(
           $urandom_range(250, 254));
      6: v[30:23] = 8'(
           $urandom_range(1, 4));
      default: v[30:23] = 8'(
           $urandom_range(1, 254));
    endcase
    return v;
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    exp_res  = '0;
    exp_flg  = '0;
    #1;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.flags",
        {29'd0, error, overflow, underflow}, 32'd0);
    #12;
    rst_n = 1'b1;

    send("div4_2", 32'h40800000, 32'h40000000);
    chk("div4_2.lit", result, 32'h40000000);
    send("neg6_3", 32'hC0C00000, 32'h40400000);
    chk("neg6_3.lit", result, 32'hC0000000);
    send("div0", 32'h40A00000, 32'h00000000);
    chk("div0.lit", result, 32'h7F800000);
    send("z_z", 32'h00000000, 32'h00000000);
    send("i_i", 32'h7F800000, 32'h7F800000);
    send("nan_a", 32'h7FC00000, 32'h40000000);
    send("nan_b", 32'h40000000, 32'h7FC00000);
    chk("nan_b.lit", result, 32'h7FC00000);
    send("sub", 32'h00400000, 32'h40000000);
    chk("sub.lit", result, 32'h00200000);
    send("tiny", 32'h00800000, 32'h7F7FFFFF);
    chk("tiny.lit", result, 32'h00000001);
    send("huge", 32'h7F7FFFFF, 32'h00800000);
    chk("huge.lit", result, 32'h7F800000);
    send("inf_0", 32'hFF800000, 32'h00000000);
    send("zero_n", 32'h80000000, 32'h40400000);
    send("n_inf", 32'h3F800000, 32'hFF800000);
    send("third", 32'h3F800000, 32'h40400000);
    send("minnorm", 32'h00FFFFFF, 32'h3FFFFFFE);
    idle("idle0");

    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h41200000;
    b = 32'h40000000;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid.res", result, 32'd0);
    chk("rstmid.flags",
        {29'd0, error, overflow, underflow}, 32'd0);
    in_valid = 1'b0;
    exp_res  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstrel.valid", {31'd0, out_valid}, 32'd0);
    idle("rstrel2");

    send("b2b0", 32'h41200000, 32'h40A00000);
    send("b2b1", 32'hC1100000, 32'h40400000);
    send("b2b2", 32'h3F800000, 32'h40E00000);
    idle("idle1");

    for (int i = 0; i < 400; i++) begin
      send("rnd", rand_op(), rand_op());
      if ($urandom_range(0, 7) == 0)
        idle("rnd_idle");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
